// File: rtl/weight_feeder_if.sv
// Load/serve bundle between the host, the weight feeder and its MAC.
// The feeder uses the slave modport; the host/MAC side uses master.
interface weight_feeder_if #(
    parameter int DATA_SIZE = 8,
    parameter int PTR_W     = 4
);
    logic                 load_valid;
    logic                 load_ready;
    logic [DATA_SIZE-1:0] load_data;
    logic                 recirc;
    logic                 win_request;
    logic [DATA_SIZE-1:0] win;
    logic                 win_valid;
    logic [PTR_W:0]       count;
    logic                 underflow;
    logic                 clear_err;

    modport slave (
        input  load_valid, load_data, recirc, win_request, clear_err,
        output load_ready, win, win_valid, count, underflow
    );

    modport master (
        output load_valid, load_data, recirc, win_request, clear_err,
        input  load_ready, win, win_valid, count, underflow
    );
endinterface

// File: rtl/weight_feeder.sv
// Weight FIFO feeding one MAC: host pushes through a valid/ready port, each
// win_request pops one weight (visible next cycle), optional tail recirculation.
module weight_feeder #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 4
) (
    input  logic            clock,
    input  logic            reset,
    weight_feeder_if.slave  bus
);
    localparam logic [PTR_W:0] ZERO_COUNT = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] ONE_COUNT  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_PTR  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W:0]       r_count;
    logic [DATA_SIZE-1:0] r_win;
    logic                 r_win_valid;
    logic                 r_underflow;

    logic                 w_load_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_dec;
    logic                 w_empty_req;
    logic                 w_wr_en;
    logic [DATA_SIZE-1:0] w_wr_data;
    logic [PTR_W:0]       w_count_next;

    // Handshake qualification, write-port selection and next occupancy.
    always_comb begin
        w_load_ready = (r_count < FULL_COUNT) && !bus.recirc;
        w_push       = bus.load_valid && w_load_ready;
        w_pop        = bus.win_request && (r_count != ZERO_COUNT);
        w_empty_req  = bus.win_request && (r_count == ZERO_COUNT);
        // A recirculating pop refills its own slot, so occupancy only drops without recirc.
        w_dec        = w_pop && !bus.recirc;
        w_wr_en      = w_push || (w_pop && bus.recirc);
        if (w_push) begin
            w_wr_data = bus.load_data;
        end else begin
            w_wr_data = r_mem[r_rd_ptr];
        end
        case ({w_push, w_dec})
            2'b10:   w_count_next = r_count + ONE_COUNT;
            2'b01:   w_count_next = r_count - ONE_COUNT;
            default: w_count_next = r_count;
        endcase
    end

    // Storage array; contents are don't-care after reset and never shown unpopped.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // Pointers, occupancy, served weight and sticky underflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_count     <= ZERO_COUNT;
            r_win       <= {DATA_SIZE{1'b0}};
            r_win_valid <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_win_valid <= w_pop;
            if (w_pop) begin
                r_win    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_empty_req) begin
                r_underflow <= 1'b1;
            end else if (bus.clear_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.win        = r_win;
    assign bus.win_valid  = r_win_valid;
    assign bus.count      = r_count;
    assign bus.underflow  = r_underflow;
endmodule
